// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and the
// MEM stage: data has priority, a streak counter bounds how long fetch can starve.
module mem_port_arbiter #(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned STREAK = 4
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready
);

    localparam logic [3:0] STREAK_MAX = STREAK[3:0];

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE
    } state_t;

    state_t     state, next_state;
    logic       grant_i, grant_d;
    logic [3:0] streak;

    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                // Fetch wins a tie only once data has used up its streak allowance.
                if (if_req && (!dm_req || streak == STREAK_MAX)) begin
                    grant_i    = 1'b1;
                    next_state = BUSY_I;
                end else if (dm_req) begin
                    grant_d    = 1'b1;
                    next_state = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ready) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= IDLE;
            streak   <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_ack   <= 1'b0;
            dm_ack   <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            state  <= next_state;
            if_ack <= (state == BUSY_I) && m_ready;
            dm_ack <= (state == BUSY_D) && m_ready;

            if (grant_i) begin
                m_req   <= 1'b1;
                m_we    <= 1'b0;
                m_addr  <= if_addr;
                m_wdata <= '0;
                streak  <= '0;
            end else if (grant_d) begin
                m_req   <= 1'b1;
                m_we    <= dm_we;
                m_addr  <= dm_addr;
                m_wdata <= dm_wdata;
                if (!if_req)                  streak <= '0;
                else if (streak != STREAK_MAX) streak <= streak + 4'd1;
            end

            if ((state == BUSY_I || state == BUSY_D) && m_ready) begin
                m_req <= 1'b0;
                if (state == BUSY_I)  if_rdata <= m_rdata;
                else if (!m_we)       dm_rdata <= m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single accesses, priority/starvation order,
// spurious handshakes, dropped requests and asynchronous reset mid-access.
module tb_mem_port_arbiter;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .STREAK(4)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns at the negedge of the first BUSY cycle; n = negedges waited.
    task automatic wait_grant(output int unsigned n);
        n = 0;
        while (m_req !== 1'b1 && n < 20) begin
            @(negedge Clock);
            n++;
        end
        check("grant_seen", {63'd0, m_req}, 64'd1);
    endtask

    // m_ready raised on the delay-th BUSY cycle; returns at the DONE negedge.
    task automatic finish(input int unsigned delay, input logic [31:0] rd);
        repeat (delay - 1) @(negedge Clock);
        m_ready = 1'b1;
        m_rdata = rd;
        @(negedge Clock);
        m_ready = 1'b0;
        m_rdata = 32'h0;
    endtask

    int unsigned n;
    logic        exp_i [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        Resetn = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; m_rdata = '0; m_ready = 1'b0;
        repeat (2) @(negedge Clock);
        check("rst_m_req", {63'd0, m_req}, 64'd0);
        check("rst_acks", {62'd0, if_ack, dm_ack}, 64'd0);
        check("rst_m_addr", {32'd0, m_addr}, 64'd0);
        check("rst_rdata", {if_rdata, dm_rdata}, 64'd0);
        Resetn = 1'b1;
        @(negedge Clock);

        // Single fetch, m_ready on 2nd BUSY cycle
        if_req = 1'b1; if_addr = 32'h40;
        wait_grant(n);
        check("fetch_lat", {32'd0, n}, 64'd1);
        check("fetch_addr", {32'd0, m_addr}, 64'h40);
        check("fetch_we", {63'd0, m_we}, 64'd0);
        @(negedge Clock);
        check("fetch_busy2", {62'd0, m_req, if_ack}, 64'd2);
        finish(1, 32'h8C220004);
        check("fetch_ack", {62'd0, if_ack, dm_ack}, 64'd2);
        check("fetch_rdata", {32'd0, if_rdata}, 64'h8C220004);
        check("fetch_done_mreq", {63'd0, m_req}, 64'd0);
        if_req = 1'b0;
        @(negedge Clock);
        check("fetch_ack_pulse", {63'd0, if_ack}, 64'd0);
        check("fetch_hold", {32'd0, if_rdata}, 64'h8C220004);

        // Single store, immediate m_ready
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
        wait_grant(n);
        check("store_we", {63'd0, m_we}, 64'd1);
        check("store_addr", {32'd0, m_addr}, 64'h100);
        check("store_wdata", {32'd0, m_wdata}, 64'hDEADBEEF);
        finish(1, 32'h12345678);
        check("store_ack", {62'd0, if_ack, dm_ack}, 64'd1);
        check("store_rdata", {32'd0, dm_rdata}, 64'd0);
        dm_req = 1'b0;
        @(negedge Clock);

        // Load, then a store that must leave dm_rdata alone
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
        wait_grant(n);
        check("load_we", {63'd0, m_we}, 64'd0);
        finish(3, 32'hCAFEF00D);
        check("load_ack", {63'd0, dm_ack}, 64'd1);
        check("load_rdata", {32'd0, dm_rdata}, 64'hCAFEF00D);
        dm_we = 1'b1; dm_addr = 32'h108; dm_wdata = 32'h55AA55AA;
        wait_grant(n);
        check("b2b_gap", {32'd0, n}, 64'd2);
        check("store2_addr", {32'd0, m_addr}, 64'h108);
        finish(1, 32'h0BADF00D);
        check("store2_ack", {63'd0, dm_ack}, 64'd1);
        check("store2_keep", {32'd0, dm_rdata}, 64'hCAFEF00D);
        dm_req = 1'b0;
        @(negedge Clock);

        // Simultaneous requests: data first, then fetch
        dm_we = 1'b0; dm_addr = 32'h200; if_addr = 32'h40;
        dm_req = 1'b1; if_req = 1'b1;
        wait_grant(n);
        check("sim_first", {32'd0, m_addr}, 64'h200);
        finish(1, 32'h1111);
        check("sim_dack", {62'd0, if_ack, dm_ack}, 64'd1);
        dm_req = 1'b0;
        wait_grant(n);
        check("sim_gap", {32'd0, n}, 64'd2);
        check("sim_second", {32'd0, m_addr}, 64'h40);
        finish(1, 32'h2222);
        check("sim_iack", {62'd0, if_ack, dm_ack}, 64'd2);
        if_req = 1'b0;
        @(negedge Clock);

        // Starvation guard: expected order D,D,D,D,I,D
        dm_req = 1'b1; if_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_grant(n);
            check($sformatf("starve_addr%0d", i), {32'd0, m_addr}, exp_i[i] ? 64'h40 : 64'h200);
            finish(1, 32'h3000 + i);
            check($sformatf("starve_ack%0d", i), {62'd0, if_ack, dm_ack}, exp_i[i] ? 64'd2 : 64'd1);
        end
        dm_req = 1'b0; if_req = 1'b0;

        // Spurious m_ready in DONE and IDLE
        m_ready = 1'b1;
        repeat (3) @(negedge Clock);
        check("spur_mreq", {63'd0, m_req}, 64'd0);
        check("spur_acks", {62'd0, if_ack, dm_ack}, 64'd0);
        m_ready = 1'b0;

        // Fetch request dropped while data access is busy
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        wait_grant(n);
        if_req = 1'b1; if_addr = 32'h44;
        @(negedge Clock);
        if_req = 1'b0;
        finish(1, 32'h4444);
        check("drop_dack", {63'd0, dm_ack}, 64'd1);
        dm_req = 1'b0;
        repeat (3) @(negedge Clock);
        check("drop_no_access", {63'd0, m_req}, 64'd0);
        check("drop_addr", {32'd0, m_addr}, 64'h300);
        check("drop_no_ack", {62'd0, if_ack, dm_ack}, 64'd0);

        // Reset in the middle of a data access
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h400; dm_wdata = 32'h77;
        wait_grant(n);
        Resetn = 1'b0;
        #1;
        check("rstmid_mreq", {63'd0, m_req}, 64'd0);
        check("rstmid_m", {m_we, m_addr, m_wdata[30:0]}, 64'd0);
        check("rstmid_rdata", {if_rdata, dm_rdata}, 64'd0);
        dm_req = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        repeat (3) @(negedge Clock);
        check("rstmid_idle", {61'd0, m_req, if_ack, dm_ack}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
